fsm_slv_issuer: RTL and testbench

Host-side initiator for the SoC communication handshake. It turns a single host request into the `command`/`interrupt`/`training`/`stop` sequence consumed by the master ownership FSM, and tracks the master's `arm` ownership flag. It releases ownership on NN completion, host abort or timeout, then reports status and run length back to the host register interface. It sits between the HPS bridge registers and the master FSM, in the same clock domain.

---
 rtl/soc_comm_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/fsm_slv_issuer.sv | 134 +++++++++++++
 tb/tb_fsm_slv_issuer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_comm_pkg.sv
// Shared codes, state encoding and output decode for the host-side handshake issuer.
package soc_comm_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b10;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_RELEASE,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [1:0] command;
    logic       interrupt;
    logic       stop;
    logic       busy;
    logic       done;
  } ctl_out_t;

  // Moore decode: everything except status/cycles follows from state and run type.
  function automatic ctl_out_t decode_ctl(input state_t st, input logic trn);
    ctl_out_t o;
    o = '{command: CMD_NONE, interrupt: 1'b0, stop: 1'b0, busy: 1'b1, done: 1'b0};
    case (st)
      S_IDLE:    o.busy = 1'b0;
      S_ISSUE:   o.command = CMD_RUN;
      S_RELEASE: begin
        o.stop      = trn;
        o.interrupt = ~trn;
      end
      S_REPORT:  o.done = 1'b1;
      default:   ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/fsm_slv_issuer.sv
// Turns a host request into the command/release handshake with the master FSM and
// reports the outcome (status, run length) back to the host registers.
module fsm_slv_issuer
  import soc_comm_pkg::*;
#(
  parameter int TO_CYC = 1_000_000,
  parameter int CNT_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_go,
  input  logic             host_train,
  input  logic             host_abort,
  input  logic             arm,
  input  logic             nn_done,
  output logic [1:0]       command,
  output logic             interrupt,
  output logic             training,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles
);

  localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_t          state, state_nxt;
  status_t         status_q, status_nxt;
  logic            training_q, training_nxt;
  logic            to_clr, cyc_clr;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  ctl_out_t        ctl;

  assign to_hit = (to_cnt == TO_LAST);

  // One timeout counter serves both ISSUE and RUN; it restarts on entry to each.
  sat_counter #(.W(TO_W)) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (to_clr),
    .en    ((state == S_ISSUE) || (state == S_RUN)),
    .cnt   (to_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cyc_clr),
    .en    (state == S_RUN),
    .cnt   (cycles)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      training_q <= 1'b0;
      status_q   <= ST_OK;
    end else begin
      training_q <= training_nxt;
      status_q   <= status_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    status_nxt   = status_q;
    training_nxt = training_q;
    to_clr       = 1'b0;
    cyc_clr      = 1'b0;
    case (state)
      S_IDLE: if (host_go) begin
        training_nxt = host_train;
        status_nxt   = ST_OK;
        to_clr       = 1'b1;
        cyc_clr      = 1'b1;
        state_nxt    = S_ISSUE;
      end
      S_ISSUE: begin
        if (arm) begin
          to_clr    = 1'b1;
          cyc_clr   = 1'b1;
          state_nxt = S_RUN;
        end else if (host_abort) begin
          status_nxt = ST_ABORT;
          state_nxt  = S_REPORT;
        end else if (to_hit) begin
          status_nxt = ST_TIMEOUT;
          state_nxt  = S_REPORT;
        end
      end
      S_RUN: begin
        // Master already gave up ownership: nothing left to release.
        if (!arm) begin
          status_nxt = ST_OK;
          state_nxt  = S_REPORT;
        end else if (nn_done) begin
          status_nxt = ST_OK;
          state_nxt  = S_RELEASE;
        end else if (host_abort) begin
          status_nxt = ST_ABORT;
          state_nxt  = S_RELEASE;
        end else if (to_hit) begin
          status_nxt = ST_TIMEOUT;
          state_nxt  = S_RELEASE;
        end
      end
      S_RELEASE: if (!arm) state_nxt = S_REPORT;
      S_REPORT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctl = decode_ctl(state, training_q);
  end

  assign command   = ctl.command;
  assign interrupt = ctl.interrupt;
  assign stop      = ctl.stop;
  assign busy      = ctl.busy;
  assign done      = ctl.done;
  assign training  = training_q;
  assign status    = status_q;

endmodule

// File: tb/tb_fsm_slv_issuer.sv
// Random and directed stimulus against a phase-level model of the issuer handshake.
module tb_fsm_slv_issuer;

  localparam int TO_CYC = 24;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0, host_go = 1'b0, host_train = 1'b0, host_abort = 1'b0;
  logic arm = 1'b0, nn_done = 1'b0;
  logic [1:0] command, status;
  logic interrupt, training, stop, busy, done;
  logic [CNT_W-1:0] cycles;

  always #5 clk = ~clk;

  fsm_slv_issuer #(.TO_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .host_go(host_go), .host_train(host_train),
    .host_abort(host_abort), .arm(arm), .nn_done(nn_done), .command(command),
    .interrupt(interrupt), .training(training), .stop(stop), .busy(busy),
    .done(done), .status(status), .cycles(cycles)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase plus elapsed-cycle bookkeeping.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_RUN = 2, P_REL = 3, P_REP = 4;
  int m_ph = P_IDLE, m_age = 0, m_run = 0, m_stat = 0;
  bit m_train = 1'b0, chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_ph = P_IDLE; m_age = 0; m_run = 0; m_stat = 0; m_train = 1'b0; chk_en = 1'b1;
    end else begin
      case (m_ph)
        P_IDLE: if (host_go) begin
          m_train = host_train; m_stat = 0; m_run = 0; m_age = 0; m_ph = P_ISSUE;
        end
        P_ISSUE: begin
          m_age++;
          if (arm) m_ph = P_RUN;
          else if (host_abort) begin m_stat = 1; m_ph = P_REP; end
          else if (m_age == TO_CYC) begin m_stat = 2; m_ph = P_REP; end
        end
        P_RUN: begin
          m_run++;
          if (!arm) begin m_stat = 0; m_ph = P_REP; end
          else if (nn_done) begin m_stat = 0; m_ph = P_REL; end
          else if (host_abort) begin m_stat = 1; m_ph = P_REL; end
          else if (m_run == TO_CYC) begin m_stat = 2; m_ph = P_REL; end
        end
        P_REL: if (!arm) m_ph = P_REP;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("command", 32'(command), (m_ph == P_ISSUE) ? 32'd2 : 32'd0);
      chk("interrupt", 32'(interrupt), 32'(m_ph == P_REL && !m_train));
      chk("stop", 32'(stop), 32'(m_ph == P_REL && m_train));
      chk("training", 32'(training), 32'(m_train));
      chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
      chk("done", 32'(done), 32'(m_ph == P_REP));
      chk("status", 32'(status), 32'(m_stat));
      chk("cycles", 32'(cycles), (m_run > MAXC) ? 32'(MAXC) : 32'(m_run));
    end
  end

  // Stimulus controls and behavioural master
  bit rnd = 1'b0, c_men = 1'b1, c_abort_lvl = 1'b0;
  int c_done_at = 0, c_abort_at = 0, c_drop_at = 0, c_rel_delay = 0;
  logic m_nxt = 1'b0;
  int rel_wait = 0;

  task automatic auto_drive();
    host_go = 1'b0;
    if (rnd) begin
      host_go    = ($urandom % 6) == 0;
      host_train = 1'($urandom % 2);
      host_abort = ($urandom % 40) == 0;
      nn_done    = ($urandom % 15) == 0;
      reset      = ($urandom % 400) != 0;
      c_rel_delay = int'($urandom % 4);
      if (host_go) c_men = ($urandom % 6) != 0;
    end else begin
      nn_done    = (m_ph == P_RUN && c_done_at != 0 && m_run + 1 == c_done_at);
      host_abort = c_abort_lvl ||
                   (m_ph == P_RUN && c_abort_at > 0 && m_run + 1 == c_abort_at) ||
                   (m_ph == P_ISSUE && c_abort_at < 0);
    end
  endtask

  // Registered master: arm follows what it saw one cycle earlier.
  task automatic master_upd();
    arm = m_nxt;
    if (!(stop || interrupt)) rel_wait = 0;
    if (!reset) begin
      arm = 1'b0; m_nxt = 1'b0; rel_wait = 0;
    end else if (command == 2'b10) m_nxt = c_men;
    else if (stop || interrupt) begin
      if (rel_wait >= c_rel_delay) m_nxt = 1'b0;
      else rel_wait++;
    end else if (!busy) m_nxt = 1'b0;
    else if (arm && ((rnd && ($urandom % 60) == 0) ||
             (!rnd && c_drop_at != 0 && m_ph == P_RUN && m_run + 1 == c_drop_at)))
      m_nxt = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    auto_drive();
    master_upd();
  endtask

  int o_cmd, o_int, o_stop, o_tbad, o_stat, o_cyc;
  bit o_done;

  task automatic txn(input bit tr, input int d_at, input int a_at, input int dr_at,
                     input int rdly, input bit men, input bit gob, input bit rst_mid);
    c_done_at = d_at; c_abort_at = a_at; c_drop_at = dr_at; c_rel_delay = rdly; c_men = men;
    o_cmd = 0; o_int = 0; o_stop = 0; o_tbad = 0; o_stat = -1; o_cyc = -1; o_done = 1'b0;
    host_go = 1'b1; host_train = tr;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (command == 2'b10) o_cmd++;
      if (interrupt) o_int++;
      if (stop) o_stop++;
      if (busy && training !== tr) o_tbad++;
      if (gob && m_ph == P_RUN && m_run == 2) begin host_go = 1'b1; host_train = ~tr; end
      if (rst_mid && m_ph == P_RUN && m_run == 3) begin
        reset = 1'b0;
        tick();
        chk("rst_command", 32'(command), 32'd0);
        chk("rst_training", 32'(training), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_release", {30'd0, stop, interrupt}, 32'd0);
        chk("rst_status_cycles", {28'd0, status, 2'(cycles)}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        return;
      end
      if (done) begin o_done = 1'b1; o_stat = status; o_cyc = 32'(cycles); break; end
    end
    chk("txn_done_seen", 32'(o_done), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    chk("reset_idle", {26'd0, command, interrupt, stop, busy, done}, 32'd0);
    chk("reset_regs", {27'd0, training, status, 2'(cycles)}, 32'd0);

    // abort level in IDLE must not start anything
    c_abort_lvl = 1'b1;
    repeat (5) tick();
    chk("idle_abort_busy", 32'(busy), 32'd0);
    c_abort_lvl = 1'b0;
    tick();

    // inference ok, with a busy-time host_go that must be ignored
    txn(1'b0, 10, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("inf_cmd_cycles", 32'(o_cmd), 32'd2);
    chk("inf_interrupt_cycles", 32'(o_int), 32'd2);
    chk("inf_no_stop", 32'(o_stop), 32'd0);
    chk("inf_training_held", 32'(o_tbad), 32'd0);
    chk("inf_status", 32'(o_stat), 32'd0);
    chk("inf_cycles", 32'(o_cyc), 32'd10);

    // training ok, master slow to release
    txn(1'b1, 10, 0, 0, 2, 1'b1, 1'b0, 1'b0);
    chk("trn_stop_cycles", 32'(o_stop), 32'd4);
    chk("trn_no_interrupt", 32'(o_int), 32'd0);
    chk("trn_training_held", 32'(o_tbad), 32'd0);
    chk("trn_status", 32'(o_stat), 32'd0);

    txn(1'b0, 0, 5, 0, 1, 1'b1, 1'b0, 1'b0);
    chk("abort_status", 32'(o_stat), 32'd1);
    chk("abort_cycles", 32'(o_cyc), 32'd5);

    txn(1'b1, 7, 7, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("abort_done_status", 32'(o_stat), 32'd0);
    chk("abort_done_cycles", 32'(o_cyc), 32'd7);

    // master never takes ownership
    txn(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("issue_to_cmd_cycles", 32'(o_cmd), 32'(TO_CYC));
    chk("issue_to_status", 32'(o_stat), 32'd2);
    chk("issue_to_cmd_after", 32'(command), 32'd0);

    txn(1'b0, 20, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("sat_cycles", 32'(o_cyc), 32'(MAXC));
    chk("sat_status", 32'(o_stat), 32'd0);

    txn(1'b1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("run_to_status", 32'(o_stat), 32'd2);
    chk("run_to_cycles", 32'(o_cyc), 32'(MAXC));

    // master drops arm by itself during RUN
    txn(1'b0, 0, 0, 6, 0, 1'b1, 1'b0, 1'b0);
    chk("drop_status", 32'(o_stat), 32'd0);
    chk("drop_cycles", 32'(o_cyc), 32'd7);
    chk("drop_no_release", 32'(o_int + o_stop), 32'd0);

    txn(1'b0, 0, -1, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("issue_abort_status", 32'(o_stat), 32'd1);
    chk("issue_abort_cmd_cycles", 32'(o_cmd), 32'd1);

    txn(1'b1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);

    rnd = 1'b1;
    repeat (4000) tick();
    rnd = 1'b0;
    reset = 1'b1; host_abort = 1'b0; nn_done = 1'b0; c_men = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
